// File: rtl/cpu_subsys_arb_pkg.sv
// Shared types and constants for the CPU subsystem memory arbiter.
package cpu_subsys_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } arb_port_e;

    // Default number of BUSY cycles before a stalled access is aborted.
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/cpu_subsys_mem_arbiter_if.sv
// Bus bundle for the memory arbiter: instruction port, data port and the
// shared memory port. The slave modport is the arbiter's view; the master
// modport is the view of the CPU requesters plus the memory macro.
interface cpu_subsys_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Port 0: instruction fetch (read-only)
    logic                  instr_req_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;
    logic                  instr_err_o;
    logic [ADDR_W-1:0]     instr_addr_i;
    logic [DATA_W-1:0]     instr_rdata_o;

    // Port 1: data load/store
    logic                  data_req_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic                  data_err_o;
    logic [ADDR_W-1:0]     data_addr_i;
    logic                  data_we_i;
    logic [DATA_W/8-1:0]   data_be_i;
    logic [DATA_W-1:0]     data_wdata_i;
    logic [DATA_W-1:0]     data_rdata_o;

    // Shared memory port
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/cpu_subsys_arb_watchdog.sv
// Bus watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th
// enabled cycle since the last clear. TIMEOUT=0 disables it (expired tied low).
module cpu_subsys_arb_watchdog
    import cpu_subsys_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused  = ^{i_clk, i_rst_n, i_clear, i_enable};
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] r_cnt;

            // The register holds completed cycles, so the current cycle is
            // r_cnt+1; expiry fires when that reaches TIMEOUT.
            assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT - 1));

            // Count enabled cycles; clear restarts the count from zero.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (i_clear) begin
                    r_cnt <= '0;
                end else if (i_enable && !o_expired) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cpu_subsys_mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (port 0) and data
// load/store (port 1) share one valid/ready memory port, one transaction
// outstanding at a time, with a watchdog that aborts stalled accesses.
// Optional macro CPU_SUBSYS_ARB_ROUND_ROBIN_EN: ties go to the port not
// granted last; otherwise data always wins ties.
module cpu_subsys_mem_arbiter
    import cpu_subsys_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    cpu_subsys_mem_arbiter_if.slave  bus
);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    arb_port_e             w_winner;
    arb_port_e             r_owner;
    logic                  w_grant;
    logic                  w_tie_to_instr;
    logic                  w_wd_expired;

    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_mem_valid;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic                  r_instr_rvalid;
    logic                  r_data_rvalid;

`ifdef CPU_SUBSYS_ARB_ROUND_ROBIN_EN
    arb_port_e             r_last;

    // Remember the most recently granted port; reset points at instr so the
    // first tie goes to data.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_INSTR;
        end else if (w_grant) begin
            r_last <= w_winner;
        end
    end

    assign w_tie_to_instr = (r_last == PORT_DATA);
`else
    assign w_tie_to_instr = 1'b0;
`endif

    // Pick the winner among current requests.
    always_comb begin
        w_winner = PORT_INSTR;
        if (bus.data_req_i && !(bus.instr_req_i && w_tie_to_instr)) begin
            w_winner = PORT_DATA;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and combinational grant; grant is held off during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n && (bus.instr_req_i || bus.data_req_i)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ready || w_wd_expired) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.instr_gnt_o = w_grant && (w_winner == PORT_INSTR);
    assign bus.data_gnt_o  = w_grant && (w_winner == PORT_DATA);

    cpu_subsys_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (sys_clk),
        .i_rst_n   (rst_n),
        .i_clear   (r_state != BUSY),
        .i_enable  (r_state == BUSY),
        .o_expired (w_wd_expired)
    );

    // Request capture, memory-side drive and response registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner        <= PORT_INSTR;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_mem_valid    <= 1'b0;
            r_rdata        <= '0;
            r_err          <= 1'b0;
            r_instr_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
        end else begin
            r_instr_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_winner;
                        r_mem_valid <= 1'b1;
                        if (w_winner == PORT_DATA) begin
                            r_addr  <= bus.data_addr_i;
                            r_wdata <= bus.data_wdata_i;
                            r_wstrb <= bus.data_we_i ? bus.data_be_i : '0;
                        end else begin
                            r_addr  <= bus.instr_addr_i;
                            r_wdata <= '0;
                            r_wstrb <= '0;
                        end
                    end
                end
                BUSY: begin
                    // mem_ready takes precedence over a coincident timeout.
                    if (bus.mem_ready) begin
                        r_mem_valid    <= 1'b0;
                        r_rdata        <= bus.mem_rdata;
                        r_err          <= 1'b0;
                        r_instr_rvalid <= (r_owner == PORT_INSTR);
                        r_data_rvalid  <= (r_owner == PORT_DATA);
                    end else if (w_wd_expired) begin
                        r_mem_valid    <= 1'b0;
                        r_rdata        <= '0;
                        r_err          <= 1'b1;
                        r_instr_rvalid <= (r_owner == PORT_INSTR);
                        r_data_rvalid  <= (r_owner == PORT_DATA);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_valid      = r_mem_valid;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_wstrb      = r_wstrb;
    assign bus.instr_rvalid_o = r_instr_rvalid;
    assign bus.data_rvalid_o  = r_data_rvalid;
    assign bus.instr_rdata_o  = r_rdata;
    assign bus.data_rdata_o   = r_rdata;
    assign bus.instr_err_o    = r_err;
    assign bus.data_err_o     = r_err;

endmodule

// File: tb/tb_cpu_subsys_mem_arbiter.sv
// Directed testbench for cpu_subsys_mem_arbiter (TIMEOUT=8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 3 units after the edge, within the same cycle.
module tb_cpu_subsys_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    cpu_subsys_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    cpu_subsys_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "global time limit reached");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = '0;
        bus.data_req_i   = 1'b0;
        bus.data_addr_i  = '0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_wdata_i = '0;
        bus.mem_ready    = 1'b0;
        bus.mem_rdata    = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        #2;
        n_total++;
        if ({bus.mem_valid, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o,
             bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.mem_valid, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o,
                      bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o});
        end else n_pass++;
        n_total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.data_rdata_o} !== 100'h0) begin
            $display("FAIL reset_data: got %h expected 0",
                     {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.data_rdata_o});
        end else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_instr_read;
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_0010;
        #2;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b10) begin
            $display("FAIL ird_gnt: got %b expected 10", {bus.instr_gnt_o, bus.data_gnt_o});
        end else n_pass++;
        tick();
        bus.instr_req_i = 1'b0;
        bus.mem_ready   = 1'b1;
        bus.mem_rdata   = 32'hDEAD_BEEF;
        #2;
        n_total++;
        if ({bus.mem_valid, bus.mem_wstrb, bus.mem_addr} !== {1'b1, 4'b0000, 32'h0000_0010}) begin
            $display("FAIL ird_mem: got %h expected %h",
                     {bus.mem_valid, bus.mem_wstrb, bus.mem_addr}, {1'b1, 4'b0000, 32'h0000_0010});
        end else n_pass++;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #2;
        n_total++;
        if ({bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.mem_valid} !== 4'b1000) begin
            $display("FAIL ird_resp_ctrl: got %b expected 1000",
                     {bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.mem_valid});
        end else n_pass++;
        n_total++;
        if (bus.instr_rdata_o !== 32'hDEAD_BEEF) begin
            $display("FAIL ird_rdata: got %h expected deadbeef", bus.instr_rdata_o);
        end else n_pass++;
        tick();
        #2;
        n_total++;
        if (bus.instr_rvalid_o !== 1'b0) begin
            $display("FAIL ird_rvalid_one_cycle: got %b expected 0", bus.instr_rvalid_o);
        end else n_pass++;
    endtask

    task automatic test_data_write;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_be_i    = 4'b0011;
        bus.data_wdata_i = 32'h1234_5678;
        bus.data_addr_i  = 32'h0000_1004;
        #2;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b01) begin
            $display("FAIL dwr_gnt: got %b expected 01", {bus.instr_gnt_o, bus.data_gnt_o});
        end else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) begin
                bus.data_req_i   = 1'b0;
                bus.data_we_i    = 1'b0;
                bus.data_be_i    = '0;
                bus.data_wdata_i = '0;
                bus.data_addr_i  = '0;
            end
            bus.mem_ready = (c == 3);
            #2;
            n_total++;
            if ({bus.mem_valid, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} !==
                {1'b1, 4'b0011, 32'h0000_1004, 32'h1234_5678}) begin
                $display("FAIL dwr_busy_c%0d: got %h expected %h", c,
                         {bus.mem_valid, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata},
                         {1'b1, 4'b0011, 32'h0000_1004, 32'h1234_5678});
            end else n_pass++;
        end
        tick();
        bus.mem_ready = 1'b0;
        #2;
        n_total++;
        if ({bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o, bus.mem_valid} !== 4'b1000) begin
            $display("FAIL dwr_resp: got %b expected 1000",
                     {bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o, bus.mem_valid});
        end else n_pass++;
        tick();
    endtask

    task automatic test_arbitration;
        logic exp_data [4];
        int   cyc;
        logic found;
`ifdef CPU_SUBSYS_ARB_ROUND_ROBIN_EN
        exp_data = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_0100;
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h0000_0200;
        bus.mem_ready    = 1'b1;
        bus.mem_rdata    = 32'h0000_00AA;
        for (int t = 0; t < 4; t++) begin
            found = 1'b0;
            cyc   = 0;
            while (!found && cyc < 8) begin
                if (t != 0 || cyc != 0) tick();
                #2;
                if (bus.instr_gnt_o || bus.data_gnt_o) found = 1'b1;
                else cyc++;
            end
            n_total++;
            if (!found) begin
                $display("FAIL arb_t%0d_wait: got no gnt expected gnt within 8 cycles", t);
                #1;
            end else if ({bus.instr_gnt_o, bus.data_gnt_o} !== (exp_data[t] ? 2'b01 : 2'b10)) begin
                $display("FAIL arb_t%0d_winner: got %b expected %b", t,
                         {bus.instr_gnt_o, bus.data_gnt_o}, (exp_data[t] ? 2'b01 : 2'b10));
            end else n_pass++;
            n_total++;
            if (cyc !== ((t == 0) ? 0 : 2)) begin
                $display("FAIL arb_t%0d_spacing: got %0d idle cycles expected %0d", t, cyc,
                         (t == 0) ? 0 : 2);
            end else n_pass++;
            #1;
        end
        bus.instr_req_i = 1'b0;
        bus.data_req_i  = 1'b0;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        int n_hi;
        bus.data_req_i  = 1'b1;
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 32'h0000_2000;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = 32'hFFFF_FFFF;
        #2;
        n_total++;
        if (bus.data_gnt_o !== 1'b1) begin
            $display("FAIL to_gnt: got %b expected 1", bus.data_gnt_o);
        end else n_pass++;
        n_hi = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.data_req_i = 1'b0;
            #2;
            if (bus.mem_valid === 1'b1 && bus.data_rvalid_o === 1'b0) n_hi++;
        end
        n_total++;
        if (n_hi !== 8) begin
            $display("FAIL to_valid_cycles: got %0d expected 8", n_hi);
        end else n_pass++;
        tick();
        #2;
        n_total++;
        if ({bus.mem_valid, bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o} !== 4'b0110) begin
            $display("FAIL to_resp: got %b expected 0110",
                     {bus.mem_valid, bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o});
        end else n_pass++;
        n_total++;
        if (bus.data_rdata_o !== 32'h0) begin
            $display("FAIL to_rdata: got %h expected 00000000", bus.data_rdata_o);
        end else n_pass++;
        tick();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_0040;
        #2;
        n_total++;
        if (bus.instr_gnt_o !== 1'b1) begin
            $display("FAIL to_next_gnt: got %b expected 1", bus.instr_gnt_o);
        end else n_pass++;
        tick();
        bus.instr_req_i = 1'b0;
        bus.mem_ready   = 1'b1;
        bus.mem_rdata   = 32'h0BAD_F00D;
        tick();
        bus.mem_ready = 1'b0;
        #2;
        n_total++;
        if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {2'b10, 32'h0BAD_F00D}) begin
            $display("FAIL to_next_resp: got %h expected %h",
                     {bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o}, {2'b10, 32'h0BAD_F00D});
        end else n_pass++;
        tick();
    endtask

    task automatic test_ready_at_expiry;
        bus.data_req_i  = 1'b1;
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 32'h0000_3000;
        bus.mem_rdata   = 32'hFFFF_FFFF;
        tick();
        bus.data_req_i = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (c == 8) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hCAFE_F00D;
            end
        end
        #2;
        n_total++;
        if (bus.mem_valid !== 1'b1) begin
            $display("FAIL rx_valid_c8: got %b expected 1", bus.mem_valid);
        end else n_pass++;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #2;
        n_total++;
        if ({bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o} !== {2'b10, 32'hCAFE_F00D}) begin
            $display("FAIL rx_resp: got %h expected %h",
                     {bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o}, {2'b10, 32'hCAFE_F00D});
        end else n_pass++;
        tick();
    endtask

    task automatic test_reset_busy;
        logic stray;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_be_i    = 4'b1111;
        bus.data_wdata_i = 32'h5555_AAAA;
        bus.data_addr_i  = 32'h0000_4000;
        tick();
        #2;
        n_total++;
        if ({bus.mem_valid, bus.mem_wstrb} !== 5'b11111) begin
            $display("FAIL rb_busy: got %b expected 11111", {bus.mem_valid, bus.mem_wstrb});
        end else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.mem_valid, bus.mem_wstrb, bus.data_gnt_o, bus.data_rvalid_o, bus.mem_addr} !== 39'h0) begin
            $display("FAIL rb_outputs: got %h expected 0",
                     {bus.mem_valid, bus.mem_wstrb, bus.data_gnt_o, bus.data_rvalid_o, bus.mem_addr});
        end else n_pass++;
        tick();
        tick();
        idle_inputs();
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            #2;
            if (bus.instr_rvalid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0 || bus.mem_valid !== 1'b0)
                stray = 1'b1;
        end
        n_total++;
        if (stray !== 1'b0) begin
            $display("FAIL rb_stray: got activity expected none");
        end else n_pass++;
        tick();
        bus.instr_req_i = 1'b1;
        bus.data_req_i  = 1'b1;
        #2;
        n_total++;
        if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b01) begin
            $display("FAIL rb_first_tie: got %b expected 01", {bus.instr_gnt_o, bus.data_gnt_o});
        end else n_pass++;
        tick();
        idle_inputs();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        idle_inputs();
        test_reset();
        test_instr_read();
        test_data_write();
        test_arbitration();
        test_timeout();
        test_ready_at_expiry();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
